mem_port_arbiter: RTL and testbench

Shares the CPU's single MIO memory port between the IF stage (instruction fetch, read-only) and the MEM stage (lw/sw). Sits between the pipeline and the memory-mapped I/O bus. It serializes requests with MEM-over-IF priority, registers all bus signals, and returns read data with a one-cycle done pulse. It drives a pipeline-wide stall that the pipeline ORs with the data-hazard stall from the control unit.

---
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side and memory-side signals of the shared
// MIO memory port, bundled for the arbiter.
//
// Handshake rules for this port:
//   - if_req / mem_req are raised by the pipeline and held until the matching
//     *_done pulse is seen.
//   - *_done is a one-cycle pulse; *_rdata is valid while *_done is high.
//   - bus_req stays high, with bus_we/bus_addr/bus_wdata stable, until the
//     memory answers with MIO_ready in the same cycle.
//   - arb_state exposes the arbiter FSM state (0 idle, 1 mem grant, 2 fetch grant).
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_done;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        MIO_ready;
   logic        stall_pipeline;
   logic        bus_error;
   logic [1:0]  arb_state;

   // Arbiter side.
   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
             bus_rdata, MIO_ready,
      output if_rdata, if_done, mem_rdata, mem_done, bus_req, bus_we,
             bus_addr, bus_wdata, stall_pipeline, bus_error, arb_state
   );

   // Pipeline plus memory side.
   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
             bus_rdata, MIO_ready,
      input  if_rdata, if_done, mem_rdata, mem_done, bus_req, bus_we,
             bus_addr, bus_wdata, stall_pipeline, bus_error, arb_state
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single MIO memory port between instruction
// fetch (read-only) and the MEM stage (loads/stores). MEM has priority; a
// requester is masked in its own done cycle, which forces a gap after each
// completion so fetch can never be starved. All bus outputs are registered.
//
// Optional feature: define ARB_TIMEOUT_EN to build a grant-cycle watchdog that
// aborts an access after TIMEOUT_CYCLES grant cycles without MIO_ready,
// returning 32'hDEAD_BEEF for reads and pulsing bus_error with the done.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave port
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT_MEM = 2'd1,
      GRANT_IF  = 2'd2
   } state_t;

   state_t      state;
   logic        bus_req_r;
   logic        bus_we_r;
   logic [31:0] bus_addr_r;
   logic [31:0] bus_wdata_r;
   logic [31:0] if_rdata_r;
   logic [31:0] mem_rdata_r;
   logic        if_done_r;
   logic        mem_done_r;
   logic        abort;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] grant_cnt;
   logic             bus_error_r;

   // The current grant cycle is the TIMEOUT_CYCLES-th one without MIO_ready;
   // a ready arriving in that same cycle still completes normally.
   assign abort = (state != IDLE) && !port.MIO_ready &&
                  (grant_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Grant-cycle counter: held at zero while idle so every grant starts fresh.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt <= '0;
      end else if (state == IDLE) begin
         grant_cnt <= '0;
      end else if (!port.MIO_ready) begin
         grant_cnt <= grant_cnt + 1'b1;
      end
   end

   assign port.bus_error = bus_error_r;
`else
   assign abort          = 1'b0;
   assign port.bus_error = 1'b0;
`endif

   // Arbitration FSM with registered bus signals, done pulses and read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         bus_req_r   <= 1'b0;
         bus_we_r    <= 1'b0;
         bus_addr_r  <= '0;
         bus_wdata_r <= '0;
         if_rdata_r  <= '0;
         mem_rdata_r <= '0;
         if_done_r   <= 1'b0;
         mem_done_r  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         bus_error_r <= 1'b0;
`endif
      end else begin
         if_done_r  <= 1'b0;
         mem_done_r <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         bus_error_r <= 1'b0;
`endif
         case (state)
            IDLE: begin
               // A requester whose done is up this cycle still holds req;
               // masking it here avoids a duplicate grant.
               if (port.mem_req && !mem_done_r) begin
                  state       <= GRANT_MEM;
                  bus_req_r   <= 1'b1;
                  bus_we_r    <= port.mem_we;
                  bus_addr_r  <= port.mem_addr;
                  bus_wdata_r <= port.mem_wdata;
               end else if (port.if_req && !if_done_r) begin
                  state       <= GRANT_IF;
                  bus_req_r   <= 1'b1;
                  bus_we_r    <= 1'b0;
                  bus_addr_r  <= port.if_addr;
                  bus_wdata_r <= '0;
               end
            end
            GRANT_MEM: begin
               if (port.MIO_ready || abort) begin
                  state      <= IDLE;
                  bus_req_r  <= 1'b0;
                  mem_done_r <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  bus_error_r <= abort;
`endif
                  // Stores leave the last load result untouched.
                  if (!bus_we_r) begin
                     mem_rdata_r <= abort ? 32'hDEAD_BEEF : port.bus_rdata;
                  end
               end
            end
            GRANT_IF: begin
               if (port.MIO_ready || abort) begin
                  state      <= IDLE;
                  bus_req_r  <= 1'b0;
                  if_done_r  <= 1'b1;
                  if_rdata_r <= abort ? 32'hDEAD_BEEF : port.bus_rdata;
`ifdef ARB_TIMEOUT_EN
                  bus_error_r <= abort;
`endif
               end
            end
            default: begin
               state     <= IDLE;
               bus_req_r <= 1'b0;
            end
         endcase
      end
   end

   assign port.bus_req   = bus_req_r;
   assign port.bus_we    = bus_we_r;
   assign port.bus_addr  = bus_addr_r;
   assign port.bus_wdata = bus_wdata_r;
   assign port.if_rdata  = if_rdata_r;
   assign port.mem_rdata = mem_rdata_r;
   assign port.if_done   = if_done_r;
   assign port.mem_done  = mem_done_r;
   assign port.arb_state = state;

   // Pipeline stall drops combinationally in the done cycle.
   assign port.stall_pipeline = (port.if_req & ~if_done_r) | (port.mem_req & ~mem_done_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized-latency checks of the memory
// port arbiter, with a queue of expected bus transactions and read data.
module tb_mem_port_arbiter;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   logic [64:0] exp_q[$];
   logic [31:0] rd_q[$];

   mem_port_arbiter_if port ();

   mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .port(port)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      port.if_req    = 1'b0;
      port.if_addr   = '0;
      port.mem_req   = 1'b0;
      port.mem_we    = 1'b0;
      port.mem_addr  = '0;
      port.mem_wdata = '0;
      port.bus_rdata = '0;
      port.MIO_ready = 1'b0;
   endtask

   // Tests
   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      checks++; if (port.bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req: got %b want 0", port.bus_req); end
      checks++; if (port.if_done !== 1'b0 || port.mem_done !== 1'b0) begin failures++; $display("FAIL reset_done: got if=%b mem=%b want 0", port.if_done, port.mem_done); end
      checks++; if (port.if_rdata !== 32'h0 || port.mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got if=%h mem=%h want 0", port.if_rdata, port.mem_rdata); end
      checks++; if ({port.bus_we, port.bus_addr, port.bus_wdata} !== 65'h0) begin failures++; $display("FAIL reset_bus_fields: got we=%b addr=%h wdata=%h want 0", port.bus_we, port.bus_addr, port.bus_wdata); end
      checks++; if (port.bus_error !== 1'b0) begin failures++; $display("FAIL reset_bus_error: got %b want 0", port.bus_error); end
      rst = 1'b0;
      step();
      checks++; if (port.arb_state !== 2'd0 || port.stall_pipeline !== 1'b0) begin failures++; $display("FAIL reset_idle: got state=%0d stall=%b want 0/0", port.arb_state, port.stall_pipeline); end
   endtask

   task automatic test_single_load();
      logic [64:0] e;
      port.mem_req = 1'b1; port.mem_we = 1'b0; port.mem_addr = 32'h100; port.mem_wdata = 32'h0;
      exp_q.push_back({1'b0, 32'h100, 32'h0});
      step();
      e = exp_q.pop_front();
      checks++; if (port.bus_req !== 1'b1 || port.arb_state !== 2'd1) begin failures++; $display("FAIL load_grant: got req=%b state=%0d want 1/1", port.bus_req, port.arb_state); end
      checks++; if ({port.bus_we, port.bus_addr, port.bus_wdata} !== e) begin failures++; $display("FAIL load_bus_fields: got %h want %h", {port.bus_we, port.bus_addr, port.bus_wdata}, e); end
      checks++; if (port.stall_pipeline !== 1'b1) begin failures++; $display("FAIL load_stall_grant: got %b want 1", port.stall_pipeline); end
      port.mem_addr = 32'h999;
      step();
      checks++; if (port.bus_addr !== 32'h100 || port.bus_req !== 1'b1) begin failures++; $display("FAIL load_addr_stable: got addr=%h req=%b want 100/1", port.bus_addr, port.bus_req); end
      step();
      checks++; if (port.bus_addr !== 32'h100 || port.mem_done !== 1'b0) begin failures++; $display("FAIL load_grant3: got addr=%h done=%b want 100/0", port.bus_addr, port.mem_done); end
      port.MIO_ready = 1'b1; port.bus_rdata = 32'h12345678;
      rd_q.push_back(32'h12345678);
      step();
      e[31:0] = rd_q.pop_front();
      checks++; if (port.mem_done !== 1'b1 || port.mem_rdata !== e[31:0]) begin failures++; $display("FAIL load_done: got done=%b rdata=%h want 1/%h", port.mem_done, port.mem_rdata, e[31:0]); end
      checks++; if (port.stall_pipeline !== 1'b0 || port.bus_req !== 1'b0) begin failures++; $display("FAIL load_done_cycle: got stall=%b req=%b want 0/0", port.stall_pipeline, port.bus_req); end
      port.mem_req = 1'b0; port.MIO_ready = 1'b0; port.bus_rdata = 32'h0;
      step();
      checks++; if (port.mem_done !== 1'b0 || port.mem_rdata !== 32'h12345678) begin failures++; $display("FAIL load_after: got done=%b rdata=%h want 0/12345678", port.mem_done, port.mem_rdata); end
   endtask

   task automatic test_collision();
      logic [64:0] e;
      logic [31:0] r;
      port.if_req = 1'b1; port.if_addr = 32'h0040;
      port.mem_req = 1'b1; port.mem_we = 1'b1; port.mem_addr = 32'h200; port.mem_wdata = 32'hCAFE0000;
      exp_q.push_back({1'b1, 32'h200, 32'hCAFE0000});
      exp_q.push_back({1'b0, 32'h0040, 32'h0});
      step();
      e = exp_q.pop_front();
      checks++; if (port.bus_req !== 1'b1 || port.arb_state !== 2'd1) begin failures++; $display("FAIL coll_mem_first: got req=%b state=%0d want 1/1", port.bus_req, port.arb_state); end
      checks++; if ({port.bus_we, port.bus_addr, port.bus_wdata} !== e) begin failures++; $display("FAIL coll_mem_fields: got %h want %h", {port.bus_we, port.bus_addr, port.bus_wdata}, e); end
      port.MIO_ready = 1'b1; port.bus_rdata = 32'hFFFF0000;
      step();
      checks++; if (port.mem_done !== 1'b1 || port.bus_req !== 1'b0 || port.if_done !== 1'b0) begin failures++; $display("FAIL coll_mem_done: got mdone=%b req=%b idone=%b want 1/0/0", port.mem_done, port.bus_req, port.if_done); end
      checks++; if (port.mem_rdata !== 32'h12345678) begin failures++; $display("FAIL coll_store_rdata: got %h want 12345678", port.mem_rdata); end
      checks++; if (port.stall_pipeline !== 1'b1) begin failures++; $display("FAIL coll_stall: got %b want 1", port.stall_pipeline); end
      port.mem_req = 1'b0; port.mem_we = 1'b0; port.MIO_ready = 1'b0;
      step();
      e = exp_q.pop_front();
      checks++; if (port.bus_req !== 1'b1 || port.arb_state !== 2'd2) begin failures++; $display("FAIL coll_if_grant: got req=%b state=%0d want 1/2", port.bus_req, port.arb_state); end
      checks++; if ({port.bus_we, port.bus_addr, port.bus_wdata} !== e) begin failures++; $display("FAIL coll_if_fields: got %h want %h", {port.bus_we, port.bus_addr, port.bus_wdata}, e); end
      port.MIO_ready = 1'b1; port.bus_rdata = 32'h00C0FFEE;
      rd_q.push_back(32'h00C0FFEE);
      step();
      r = rd_q.pop_front();
      checks++; if (port.if_done !== 1'b1 || port.if_rdata !== r || port.mem_done !== 1'b0) begin failures++; $display("FAIL coll_if_done: got done=%b rdata=%h mdone=%b want 1/%h/0", port.if_done, port.if_rdata, port.mem_done, r); end
      port.if_req = 1'b0; port.MIO_ready = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [64:0] e;
      logic [31:0] r;
      int          lat;
      port.if_req = 1'b1; port.if_addr = 32'h1000;
      exp_q.push_back({1'b0, 32'h1000, 32'h0});
      step();
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++; if (port.bus_req !== 1'b1 || {port.bus_we, port.bus_addr, port.bus_wdata} !== e) begin failures++; $display("FAIL b2b_grant%0d: got req=%b fields=%h want 1/%h", k, port.bus_req, {port.bus_we, port.bus_addr, port.bus_wdata}, e); end
         lat = $urandom_range(1, 3);
         repeat (lat - 1) step();
         port.MIO_ready = 1'b1; port.bus_rdata = $urandom;
         rd_q.push_back(port.bus_rdata);
         step();
         r = rd_q.pop_front();
         checks++; if (port.if_done !== 1'b1 || port.if_rdata !== r) begin failures++; $display("FAIL b2b_done%0d: got done=%b rdata=%h want 1/%h", k, port.if_done, port.if_rdata, r); end
         port.MIO_ready = 1'b0;
         if (k < 3) begin
            port.if_addr = 32'h1000 + 32'(4 * (k + 1));
            exp_q.push_back({1'b0, port.if_addr, 32'h0});
         end else begin
            port.if_req = 1'b0;
         end
         step();
         checks++; if (port.bus_req !== 1'b0 || port.if_done !== 1'b0 || port.arb_state !== 2'd0) begin failures++; $display("FAIL b2b_no_dup%0d: got req=%b done=%b state=%0d want 0/0/0", k, port.bus_req, port.if_done, port.arb_state); end
         step();
      end
      checks++; if (port.bus_req !== 1'b0) begin failures++; $display("FAIL b2b_end_idle: got %b want 0", port.bus_req); end
   endtask

   task automatic test_reset_mid_grant();
      port.if_req = 1'b1; port.if_addr = 32'h0080;
      step();
      step();
      checks++; if (port.bus_req !== 1'b1 || port.arb_state !== 2'd2) begin failures++; $display("FAIL rstmid_grant: got req=%b state=%0d want 1/2", port.bus_req, port.arb_state); end
      #2 rst = 1'b1;
      #1;
      checks++; if (port.bus_req !== 1'b0 || port.arb_state !== 2'd0) begin failures++; $display("FAIL rstmid_async: got req=%b state=%0d want 0/0", port.bus_req, port.arb_state); end
      port.if_req = 1'b0;
      step();
      rst = 1'b0;
      checks++; if (port.if_rdata !== 32'h0 || port.mem_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_rdata: got if=%h mem=%h want 0/0", port.if_rdata, port.mem_rdata); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (port.if_done !== 1'b0 || port.arb_state !== 2'd0 || port.bus_req !== 1'b0) begin failures++; $display("FAIL rstmid_after%0d: got done=%b state=%0d req=%b want 0/0/0", i, port.if_done, port.arb_state, port.bus_req); end
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      port.if_req = 1'b1; port.if_addr = 32'h0090; port.MIO_ready = 1'b0;
      step();
      for (int g = 1; g <= TO; g++) begin
         checks++; if (port.bus_req !== 1'b1 || port.bus_error !== 1'b0 || port.if_done !== 1'b0) begin failures++; $display("FAIL to_grant%0d: got req=%b err=%b done=%b want 1/0/0", g, port.bus_req, port.bus_error, port.if_done); end
         step();
      end
      checks++; if (port.if_done !== 1'b1 || port.bus_error !== 1'b1 || port.bus_req !== 1'b0) begin failures++; $display("FAIL to_abort: got done=%b err=%b req=%b want 1/1/0", port.if_done, port.bus_error, port.bus_req); end
      checks++; if (port.if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL to_rdata: got %h want deadbeef", port.if_rdata); end
      port.if_req = 1'b0;
      step();
      checks++; if (port.bus_error !== 1'b0 || port.if_done !== 1'b0) begin failures++; $display("FAIL to_after: got err=%b done=%b want 0/0", port.bus_error, port.if_done); end
   endtask

   task automatic test_timeout_race();
      port.if_req = 1'b1; port.if_addr = 32'h0094; port.MIO_ready = 1'b0;
      step();
      repeat (TO - 1) step();
      port.MIO_ready = 1'b1; port.bus_rdata = 32'h0BADF00D;
      rd_q.push_back(32'h0BADF00D);
      step();
      checks++; if (port.if_done !== 1'b1 || port.bus_error !== 1'b0) begin failures++; $display("FAIL race_done: got done=%b err=%b want 1/0", port.if_done, port.bus_error); end
      checks++; if (port.if_rdata !== rd_q.pop_front()) begin failures++; $display("FAIL race_rdata: got %h want 0badf00d", port.if_rdata); end
      port.if_req = 1'b0; port.MIO_ready = 1'b0;
      step();
   endtask
`else
   task automatic test_no_timeout();
      int bad;
      bad = 0;
      port.if_req = 1'b1; port.if_addr = 32'h00A0; port.MIO_ready = 1'b0;
      step();
      for (int g = 0; g < 30; g++) begin
         if (port.bus_req !== 1'b1 || port.bus_error !== 1'b0 || port.if_done !== 1'b0) bad++;
         step();
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL wait_forever: got %0d bad grant cycles want 0", bad); end
      port.MIO_ready = 1'b1; port.bus_rdata = 32'h13579BDF;
      rd_q.push_back(32'h13579BDF);
      step();
      checks++; if (port.if_done !== 1'b1 || port.if_rdata !== rd_q.pop_front() || port.bus_error !== 1'b0) begin failures++; $display("FAIL wait_done: got done=%b rdata=%h err=%b want 1/13579bdf/0", port.if_done, port.if_rdata, port.bus_error); end
      port.if_req = 1'b0; port.MIO_ready = 1'b0;
      step();
   endtask
`endif

   // Sequence and final report
   initial begin
      test_reset();
      test_single_load();
      test_collision();
      test_back_to_back();
      test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
      test_timeout_race();
`else
      test_no_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
